// File: rtl/tc_hdd_master.sv
// tc_hdd_master: initiator for the TC_Hdd relative-seek disk.
// Turns absolute-address read/write bursts into seek/load/save sequences,
// keeping a local copy of the disk pointer so the host never sees relative seeks.
module tc_hdd_master #(
  parameter int LEN_WIDTH = 16,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [63:0]          req_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [63:0]          wr_data,
  output logic                 rd_valid,
  output logic [63:0]          rd_data,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [63:0]          hdd_seek,
  output logic                 hdd_load,
  output logic                 hdd_save,
  output logic [63:0]          hdd_in,
  input  logic [63:0]          hdd_out
);

  typedef enum logic [2:0] {IDLE, SEEK, XFER, DRAIN, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 write_reg, write_next;
  logic [63:0]          addr_reg, addr_next;
  logic [LEN_WIDTH-1:0] rem_reg, rem_next;
  logic                 rej_reg, rej_next;
  logic [63:0]          pos_reg;
  logic                 rd_valid_reg;

  // Range check is done in 65 bits so addr+len cannot wrap past the limit.
  logic [64:0] end_addr;
  logic        req_bad;
  assign end_addr = {1'b0, req_addr} + {{(65-LEN_WIDTH){1'b0}}, req_len};
  assign req_bad  = (req_len == '0) || (req_addr >= 64'(DEPTH)) || (end_addr > 65'(DEPTH));

  // Status outputs; everything is forced quiet while rst is held.
  assign req_ready = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE) && !rst;
  assign done      = (state_reg == DONE) && !rst;
  assign err       = done && rej_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = hdd_out;

  // Next-state and disk command decode.
  always_comb begin
    state_next = state_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    rej_next   = rej_reg;
    hdd_seek   = '0;
    hdd_load   = 1'b0;
    hdd_save   = 1'b0;
    hdd_in     = '0;
    wr_ready   = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_next = req_write;
            addr_next  = req_addr;
            rem_next   = req_len;
            rej_next   = req_bad;
            if (req_bad)
              state_next = DONE;
            else if (req_addr == pos_reg)
              state_next = XFER;
            else
              state_next = SEEK;
          end
        end
        SEEK: begin
          // Two's-complement delta: backward moves simply wrap.
          hdd_seek   = addr_reg - pos_reg;
          state_next = XFER;
        end
        XFER: begin
          if (write_reg) begin
            wr_ready = 1'b1;
            if (wr_valid) begin
              hdd_save = 1'b1;
              hdd_in   = wr_data;
              hdd_seek = 64'd1;
              rem_next = rem_reg - LEN_WIDTH'(1);
              if (rem_reg == LEN_WIDTH'(1))
                state_next = DONE;
            end
          end else begin
            hdd_load = 1'b1;
            hdd_seek = 64'd1;
            rem_next = rem_reg - LEN_WIDTH'(1);
            if (rem_reg == LEN_WIDTH'(1))
              state_next = DRAIN;
          end
        end
        DRAIN: state_next = DONE;
        DONE: begin
          state_next = IDLE;
          rej_next   = 1'b0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, request latch, pointer mirror and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      rem_reg      <= '0;
      rej_reg      <= 1'b0;
      pos_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      write_reg    <= write_next;
      addr_reg     <= addr_next;
      rem_reg      <= rem_next;
      rej_reg      <= rej_next;
      pos_reg      <= pos_reg + hdd_seek;
      rd_valid_reg <= hdd_load;
    end
  end

endmodule

// File: tb/tb_tc_hdd_master.sv
// Directed testbench for tc_hdd_master with a behavioural TC_Hdd disk model.
module tb_tc_hdd_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_data = '0;
  logic        req_ready, wr_ready, rd_valid, done, err, busy;
  logic        hdd_load, hdd_save;
  logic [63:0] rd_data, hdd_seek, hdd_in;
  logic [63:0] hdd_out;

  int passed = 0;
  int total  = 0;

  logic [63:0] gold [0:255];

  always #5 clk = ~clk;

  tc_hdd_master #(.LEN_WIDTH(16), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err), .busy(busy),
    .hdd_seek(hdd_seek), .hdd_load(hdd_load), .hdd_save(hdd_save),
    .hdd_in(hdd_in), .hdd_out(hdd_out)
  );

  // Disk model: pointer and load on posedge, save on negedge at current pointer.
  logic [63:0] mem [0:255];
  logic [63:0] mp;
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mp      <= '0;
      hdd_out <= '0;
    end else begin
      mp <= mp + hdd_seek;
      if (hdd_load) hdd_out <= mem[mp[7:0]];
    end
  end

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 64'h11 * 64'(i + 1);
      mem_init = 1'b1;
    end else if (hdd_save) begin
      mem[mp[7:0]] = hdd_in;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input int a, input int n, input bit need_seek, input logic [63:0] sv);
    cyc();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'(a); req_len = 16'(n);
    #1;
    chk("rd_req_ready", req_ready, 1);
    if (need_seek) begin
      cyc(); req_valid = 1'b0; #1;
      chk("rd_seek_delta", hdd_seek, sv);
      chk("rd_seek_noload", hdd_load, 0);
    end
    for (int k = 0; k < n; k++) begin
      cyc(); req_valid = 1'b0; #1;
      chk("rd_load", hdd_load, 1);
      chk("rd_step", hdd_seek, 1);
      chk("rd_valid_xfer", rd_valid, (k > 0) ? 1 : 0);
      if (k > 0) chk("rd_data", rd_data, gold[a + k - 1]);
    end
    cyc(); #1;
    chk("drain_rd_valid", rd_valid, 1);
    chk("drain_rd_data", rd_data, gold[a + n - 1]);
    chk("drain_load", hdd_load, 0);
    chk("drain_seek", hdd_seek, 0);
    chk("drain_done", done, 0);
    cyc(); #1;
    chk("rd_done", done, 1);
    chk("rd_err", err, 0);
    chk("rd_valid_done", rd_valid, 0);
  endtask

  task automatic write_burst(input int a, input int n, input bit need_seek, input logic [63:0] sv,
                             input int gap, input logic [63:0] base);
    cyc();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'(a); req_len = 16'(n);
    #1;
    chk("wr_req_ready", req_ready, 1);
    if (need_seek) begin
      cyc(); req_valid = 1'b0; #1;
      chk("wr_seek_delta", hdd_seek, sv);
      chk("wr_seek_nosave", hdd_save, 0);
      chk("wr_seek_wr_ready", wr_ready, 0);
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          cyc(); req_valid = 1'b0; wr_valid = 1'b0; #1;
          chk("stall_wr_ready", wr_ready, 1);
          chk("stall_save", hdd_save, 0);
          chk("stall_seek", hdd_seek, 0);
        end
      end
      cyc(); req_valid = 1'b0; wr_valid = 1'b1; wr_data = base + 64'(k); #1;
      chk("wr_save", hdd_save, 1);
      chk("wr_step", hdd_seek, 1);
      chk("wr_in", hdd_in, base + 64'(k));
      gold[a + k] = base + 64'(k);
    end
    cyc(); wr_valid = 1'b0; #1;
    chk("wr_done", done, 1);
    chk("wr_err", err, 0);
    chk("wr_done_save", hdd_save, 0);
    chk("wr_done_wr_ready", wr_ready, 0);
  endtask

  task automatic reject(input logic [63:0] a, input int n);
    cyc();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = 16'(n);
    #1;
    chk("rej_req_ready", req_ready, 1);
    cyc(); req_valid = 1'b0; #1;
    chk("rej_done", done, 1);
    chk("rej_err", err, 1);
    chk("rej_load", hdd_load, 0);
    chk("rej_save", hdd_save, 0);
    chk("rej_seek", hdd_seek, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < 256; i++) gold[i] = 64'h11 * 64'(i + 1);
    cyc();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", hdd_load, 0);
    chk("rst_seek", hdd_seek, 0);
    chk("rst_rd_valid", rd_valid, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    read_burst(0, 4, 1'b0, 64'd0);                                // pos 4
    write_burst(10, 3, 1'b1, 64'd6, 0, 64'hA0);                   // pos 13
    read_burst(10, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);             // pos 13
    write_burst(20, 2, 1'b1, 64'd7, 3, 64'hB0);                   // pos 22
    reject(64'd0, 0);
    reject(64'd250, 10);
    reject(64'd256, 1);
    read_burst(22, 1, 1'b0, 64'd0);                               // pos 23

    // Reset during the third word of an 8-word read.
    cyc();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd0; req_len = 16'd8;
    #1;
    chk("mid_req_ready", req_ready, 1);
    cyc(); req_valid = 1'b0; #1;
    chk("mid_seek", hdd_seek, 64'hFFFF_FFFF_FFFF_FFE9);
    cyc(); #1;
    chk("mid_load0", hdd_load, 1);
    cyc(); #1;
    chk("mid_rd_data0", rd_data, gold[0]);
    cyc(); rst = 1'b1; #1;
    chk("mid_rst_load", hdd_load, 0);
    cyc(); rst = 1'b0; #1;
    chk("mid_busy", busy, 0);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_done", done, 0);
    cyc(); #1;
    chk("mid_done_next", done, 0);

    read_burst(0, 2, 1'b0, 64'd0);                                // pos 2
    read_burst(5, 1, 1'b1, 64'd3);                                // pos 6
    read_burst(6, 1, 1'b0, 64'd0);                                // pos 7

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tc_hdd_master.md
Name: tc_hdd_master

Overview:
- Initiator for the TC_Hdd relative-seek disk interface (seek/load/save/in/out).
- Converts absolute-address burst requests (valid/ready) into the Hdd's relative-seek command sequence and streams 64-bit words in or out.
- Tracks the disk's internal pointer locally, so the CPU/host side never deals with relative seeks.
- Sits between a host bus adapter and a TC_Hdd instance sharing the same clk/rst.

Parameters:
- LEN_WIDTH, 16, width of burst length field in words.
- DEPTH, 256, word capacity of the attached disk; requests with addr+len > DEPTH are rejected.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset; must be the same rst driving the attached TC_Hdd.
- req_valid  input  1  request offered.
- req_ready  output  1  high only in IDLE.
- req_write  input  1  1 = write burst, 0 = read burst.
- req_addr  input  64  absolute start word address.
- req_len  input  LEN_WIDTH  number of words.
- wr_valid  input  1  write data offered.
- wr_ready  output  1  write word accepted this cycle.
- wr_data  input  64  write word.
- rd_valid  output  1  rd_data holds a read word; no backpressure.
- rd_data  output  64  read word.
- done  output  1  one-cycle pulse when a request ends.
- err  output  1  one-cycle pulse coincident with done for rejected requests.
- busy  output  1  state != IDLE.
- hdd_seek  output  64  to TC_Hdd seek.
- hdd_load  output  1  to TC_Hdd load.
- hdd_save  output  1  to TC_Hdd save.
- hdd_in  output  64  to TC_Hdd in.
- hdd_out  input  64  from TC_Hdd out.

Behaviour:
- Disk model:
  - Each posedge: mp <= mp + seek; if load, out <= mem[old mp].
  - save writes mem[mp] at negedge of the same cycle, using the current (pre-increment) mp.
- pos register mirrors mp.
  - Reset value 0.
  - Updated every posedge by pos <= pos + hdd_seek, mod 2^64.
- Reset values:
  - Outputs: req_ready=0 during the rst cycle, then 1; wr_ready, rd_valid, done, err, busy, hdd_load, hdd_save = 0; hdd_seek, hdd_in, rd_data = 0.
  - State: IDLE; pos=0; counters 0.
- State IDLE:
  - req_ready=1 and all hdd_* = 0.
  - On req_valid: latch write, addr, len, remaining count.
  - Rejection: if len==0, or addr >= DEPTH, or addr+len > DEPTH (computed in 65 bits) -> DONE with err.
  - Otherwise, if addr==pos -> XFER, else -> SEEK.
- State SEEK (exactly 1 cycle):
  - hdd_seek = addr - pos (64-bit wrap), load=save=0.
  - Next state XFER; pos then equals addr.
- State XFER, read:
  - Every cycle: hdd_load=1, hdd_seek=1, remaining--.
  - On the last word -> DRAIN.
- State XFER, write:
  - wr_ready=1.
  - If wr_valid: hdd_save=1, hdd_in=wr_data, hdd_seek=1, remaining--.
  - If !wr_valid: seek=0, save=0 (stall, pos unchanged).
  - After the last accepted word -> DONE.
- State DRAIN (1 cycle): hdd_seek=0, load=0, then -> DONE.
- State DONE (1 cycle):
  - done=1; err=1 only on rejection.
  - Then -> IDLE.
  - A new request can be accepted the cycle after done.
- Read data path:
  - rd_valid is registered and equals the previous cycle's hdd_load.
  - rd_data = hdd_out combinationally.
  - Read words appear at 1 word/cycle, starting the cycle after the first load.
  - Exactly len rd_valid pulses per read; the last one coincides with DRAIN.
- Request timing: request-accept to first load is 1 cycle (pos hit) or 2 cycles (seek needed).
- Final pointer: after a burst, pos = addr + len.
- Reset mid-operation: abort immediately to IDLE with pos=0, all hdd_* low; no done pulse; partial writes stay in the disk.
- req_valid outside IDLE is ignored; no request queueing.
- Address arithmetic: the seek delta is two's-complement, so backward seeks wrap (e.g. pos=10, addr=3 -> seek = 2^64-7).

Test Plan:
- After reset, read addr=0 len=4 (mem = 0x11,0x22,0x33,0x44) -> no SEEK cycle; load high 4 cycles with seek=1; rd_data 0x11..0x44 on 4 consecutive cycles; done 1 cycle after the last rd_valid; pos=4.
- Write addr=10 len=3 data A,B,C from pos=4 -> one SEEK cycle with hdd_seek=6, then 3 save cycles; read back addr=10 len=3 returns A,B,C with seek = 2^64-3.
- Write len=2 with wr_valid low for 3 cycles between words -> save and seek are 0 during the gap; exactly 2 saves; pos = addr+2.
- Rejections: len=0; addr=250 len=10 with DEPTH=256; addr=256 -> each gives done and err in the same cycle, no hdd_* activity, pos unchanged.
- Assert rst during the third word of an 8-word read -> next cycle busy=0, rd_valid=0, no done; a subsequent read addr=0 issues no seek.
- Back-to-back reads addr=5 len=1 then addr=6 len=1 -> second request needs no SEEK (pos=6); each returns the correct word.
